// File: rtl/oled_pixel_streamer_if.sv
// oled_pixel_streamer_if
//   Groups the coordinate/colour link to the renderer mux and the OLED
//   serial pins of one oled_pixel_streamer into a single bundle.
//   master : the streamer (drives coordinates, panel pins and status)
//   slave  : the renderer/panel side (drives enable, pixel_color)
//   Signals: enable, pixel_color[15:0], coordinate_x[7:0], coordinate_y[6:0],
//            oled_cs_n, oled_sclk, oled_sdin, oled_dc, frame_start,
//            frame_done, busy, and test_mode when
//            OLED_STREAMER_TESTPATTERN_EN is defined.
interface oled_pixel_streamer_if;
  logic        enable;
  logic [15:0] pixel_color;
  logic [7:0]  coordinate_x;
  logic [6:0]  coordinate_y;
  logic        oled_cs_n;
  logic        oled_sclk;
  logic        oled_sdin;
  logic        oled_dc;
  logic        frame_start;
  logic        frame_done;
  logic        busy;
`ifdef OLED_STREAMER_TESTPATTERN_EN
  logic        test_mode;

  modport master (
    input  enable, pixel_color, test_mode,
    output coordinate_x, coordinate_y, oled_cs_n, oled_sclk, oled_sdin,
           oled_dc, frame_start, frame_done, busy
  );

  modport slave (
    output enable, pixel_color, test_mode,
    input  coordinate_x, coordinate_y, oled_cs_n, oled_sclk, oled_sdin,
           oled_dc, frame_start, frame_done, busy
  );
`else
  modport master (
    input  enable, pixel_color,
    output coordinate_x, coordinate_y, oled_cs_n, oled_sclk, oled_sdin,
           oled_dc, frame_start, frame_done, busy
  );

  modport slave (
    output enable, pixel_color,
    input  coordinate_x, coordinate_y, oled_cs_n, oled_sclk, oled_sdin,
           oled_dc, frame_start, frame_done, busy
  );
`endif
endinterface

// File: rtl/oled_pixel_streamer.sv
// oled_pixel_streamer
//   Scans a WIDTH x HEIGHT raster (x fastest), presents each coordinate to
//   the renderer, captures the RGB565 colour it returns after COLOR_LATENCY
//   cycles and shifts it MSB first to the OLED panel. The panel samples
//   oled_sdin on the rising edge of oled_sclk. One pixel costs
//   COLOR_LATENCY + 32*SCLK_HALF + 1 cycles; frames run back to back while
//   enable stays high, and a frame is never truncated by enable.
//   Ports: faster_clk (pixel clock), rst_n (async active-low reset),
//          bus (oled_pixel_streamer_if.master, see interface header).
//   Optional: OLED_STREAMER_TESTPATTERN_EN adds bus.test_mode, which (when
//   latched high at frame start) replaces pixel_color by RGB colour bars.
module oled_pixel_streamer #(
  parameter int WIDTH         = 96,
  parameter int HEIGHT        = 64,
  parameter int SCLK_HALF     = 2,
  parameter int COLOR_LATENCY = 2
) (
  input logic                   faster_clk,
  input logic                   rst_n,
  oled_pixel_streamer_if.master bus
);

  localparam int WAIT_W = (COLOR_LATENCY > 1) ? $clog2(COLOR_LATENCY) : 1;
  localparam int HALF_W = $clog2(2 * SCLK_HALF);

  localparam logic [7:0]        X_LAST    = 8'(WIDTH - 1);
  localparam logic [6:0]        Y_LAST    = 7'(HEIGHT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(COLOR_LATENCY - 1);
  localparam logic [HALF_W-1:0] LOW_LAST  = HALF_W'(SCLK_HALF - 1);
  localparam logic [HALF_W-1:0] HIGH_LAST = HALF_W'(2 * SCLK_HALF - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, NEXT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic [15:0]       shreg_q, shreg_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [15:0]       load_color;
  logic              tm_q, tm_d;

  // Colour loaded into the shifter: either the renderer's answer or, when
  // the frame was started in test mode, bars chosen from the column.
`ifdef OLED_STREAMER_TESTPATTERN_EN
  always_comb begin
    load_color = bus.pixel_color;
    if (tm_q) begin
      if (x_q < 8'd32)      load_color = 16'hF800;
      else if (x_q < 8'd64) load_color = 16'h07E0;
      else                  load_color = 16'h001F;
    end
  end
  assign tm_d = bus.test_mode;
`else
  assign load_color = bus.pixel_color;
  assign tm_d       = 1'b0;
`endif

  // Next-state logic. Each serial bit is a low phase then a high phase of
  // SCLK_HALF cycles; sdin (shreg bit 15) only moves on the edge that ends
  // a high phase, so it is stable across every rising edge.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    cs_n_d        = cs_n_q;
    sclk_d        = sclk_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    busy_d        = busy_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    wait_d        = wait_q;
    half_d        = half_q;
    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        if (bus.enable) begin
          x_d           = 8'd0;
          y_d           = 7'd0;
          cs_n_d        = 1'b0;
          busy_d        = 1'b1;
          frame_start_d = 1'b1;
          wait_d        = '0;
          state_d       = FETCH;
        end
      end
      FETCH: begin
        if (wait_q == WAIT_LAST) begin
          shreg_d   = load_color;
          bit_cnt_d = 4'd15;
          half_d    = '0;
          sclk_d    = 1'b0;
          state_d   = SHIFT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      SHIFT: begin
        if (half_q == LOW_LAST) begin
          sclk_d = 1'b1;
          half_d = half_q + HALF_W'(1);
        end else if (half_q == HIGH_LAST) begin
          if (bit_cnt_q == 4'd0) begin
            state_d = NEXT;
          end else begin
            shreg_d   = {shreg_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 4'd1;
            half_d    = '0;
            sclk_d    = 1'b0;
          end
        end else begin
          half_d = half_q + HALF_W'(1);
        end
      end
      NEXT: begin
        wait_d  = '0;
        state_d = FETCH;
        if (x_q == X_LAST && y_q == Y_LAST) begin
          frame_done_d = 1'b1;
          x_d          = 8'd0;
          y_d          = 7'd0;
          if (bus.enable) begin
            frame_start_d = 1'b1;
          end else begin
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (x_q == X_LAST) begin
          x_d = 8'd0;
          y_d = y_q + 7'd1;
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; test_mode is latched only when a frame begins.
  always_ff @(posedge faster_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= 8'd0;
      y_q           <= 7'd0;
      cs_n_q        <= 1'b1;
      sclk_q        <= 1'b1;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      shreg_q       <= 16'd0;
      bit_cnt_q     <= 4'd0;
      wait_q        <= '0;
      half_q        <= '0;
      tm_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cs_n_q        <= cs_n_d;
      sclk_q        <= sclk_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      wait_q        <= wait_d;
      half_q        <= half_d;
      if (frame_start_d) tm_q <= tm_d;
    end
  end

  assign bus.coordinate_x = x_q;
  assign bus.coordinate_y = y_q;
  assign bus.oled_cs_n    = cs_n_q;
  assign bus.oled_sclk    = sclk_q;
  assign bus.oled_sdin    = shreg_q[15];
  assign bus.oled_dc      = 1'b1;
  assign bus.frame_start  = frame_start_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// tb_oled_pixel_streamer
//   Drives oled_pixel_streamer with a small raster (96 x 2, SCLK_HALF=1) so
//   several complete frames fit in a short run. A renderer model answers
//   each coordinate with a per-frame colour rule after a two-cycle
//   pipeline; a panel model reassembles words from sdin on sclk rising
//   edges and compares them, in raster order, with the colour the rule
//   gives for that pixel index.
module tb_oled_pixel_streamer;

  localparam int W   = 96;
  localparam int H   = 2;
  localparam int SH  = 1;
  localparam int L   = 2;
  localparam int N   = W * H;
  localparam int PIX = L + 32 * SH + 1;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  oled_pixel_streamer_if bus ();

  oled_pixel_streamer #(
    .WIDTH(W), .HEIGHT(H), .SCLK_HALF(SH), .COLOR_LATENCY(L)
  ) dut (
    .faster_clk(clk),
    .rst_n     (rstN),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  int cycleNum   = 0;
  int frameNum   = 0;
  int doneNum    = 0;
  int pixIdx     = 0;
  int bitCount   = 0;
  int runLen     = 0;
  int startCycle = 0;
  int monFrame   = 0;
  logic [15:0] shiftWord = 16'd0;
  logic [15:0] stage1    = 16'd0;
  logic        prevSclk  = 1'b1;
  logic        prevSdin  = 1'b0;

  logic [1:0]  frameMode     [8];
  logic [15:0] frameSeed     [8];
  logic        frameTm       [8];
  logic        doneWithStart [8];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Renderer colour rules: 0 constant seed, 1 {x,y,0}, 2 seeded hash.
  function automatic logic [15:0] renderColor(input int fi, input int x, input int y);
    logic [31:0] t;
    case (frameMode[fi])
      2'd0:    return frameSeed[fi];
      2'd1:    return {8'(x), 7'(y), 1'b0};
      default: begin
        t = x * 40503 + y * 31161;
        return frameSeed[fi] ^ t[15:0];
      end
    endcase
  endfunction

  // What the panel must receive as the idx-th word of frame fi.
  function automatic logic [15:0] expectedWord(input int fi, input int idx);
    int x;
    int y;
    x = idx % W;
    y = idx / W;
`ifdef OLED_STREAMER_TESTPATTERN_EN
    if (frameTm[fi]) begin
      if (x < 32)      return 16'hF800;
      else if (x < 64) return 16'h07E0;
      else             return 16'h001F;
    end
`endif
    return renderColor(fi, x, y);
  endfunction

  // Panel model, frame bookkeeping and renderer pipeline, all evaluated
  // mid-cycle so every DUT output is settled.
  always @(negedge clk) begin
    if (!rstN) begin
      pixIdx   = 0;
      bitCount = 0;
      runLen   = 0;
      prevSclk = 1'b1;
      prevSdin = 1'b0;
    end else begin
      cycleNum++;
      if (bus.frame_done) begin
        doneWithStart[doneNum % 8] = bus.frame_start;
        doneNum++;
        checkOutput("donePixels", pixIdx, N);
        checkOutput("doneCycles", cycleNum - startCycle, N * PIX);
        pixIdx = 0;
      end
      if (bus.frame_start) begin
        frameNum++;
        checkOutput("startPixel", pixIdx, 0);
        checkOutput("startCoord", {bus.coordinate_x, bus.coordinate_y}, 0);
        startCycle = cycleNum;
      end
      if (bus.oled_sdin !== prevSdin) checkOutput("sdinWhileHigh", prevSclk, 1);
      if (bus.oled_sclk !== prevSclk) begin
        if (prevSclk == 1'b0)  checkOutput("sclkLowLen", runLen, SH);
        else if (bitCount > 0) checkOutput("sclkHighLen", runLen, SH);
        runLen = 1;
      end else begin
        runLen++;
      end
      if (prevSclk == 1'b0 && bus.oled_sclk == 1'b1) begin
        shiftWord = {shiftWord[14:0], bus.oled_sdin};
        bitCount++;
        if (bitCount == 16) begin
          monFrame = (frameNum > 0) ? (frameNum - 1) % 8 : 0;
          checkOutput("pixelWord", shiftWord, expectedWord(monFrame, pixIdx));
          checkOutput("linkActive", {bus.oled_cs_n, bus.busy, bus.oled_dc}, 3'b011);
          pixIdx++;
          bitCount = 0;
        end
      end
      prevSclk = bus.oled_sclk;
      prevSdin = bus.oled_sdin;
      monFrame = (frameNum > 0) ? (frameNum - 1) % 8 : 0;
      bus.pixel_color = stage1;
      stage1 = renderColor(monFrame, int'(bus.coordinate_x), int'(bus.coordinate_y));
    end
  end

  task automatic applyStimulus(input logic en, input int cycles);
    bus.enable = en;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitDone(input int target, input int budget);
    int n;
    n = 0;
    while (doneNum < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneReached", doneNum >= target, 1);
  endtask

  // Waits until frame frm (1-based count) has emitted idx words and the
  // serial clock is in a low phase.
  task automatic waitPixel(input int frm, input int idx, input int budget);
    int n;
    n = 0;
    while (!(frameNum == frm && pixIdx >= idx && bus.oled_sclk == 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pixelReached", n < budget, 1);
  endtask

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: observed no end, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    bus.enable      = 1'b0;
    bus.pixel_color = 16'd0;
`ifdef OLED_STREAMER_TESTPATTERN_EN
    bus.test_mode   = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      frameMode[i]     = 2'd2;
      frameSeed[i]     = 16'($urandom);
      frameTm[i]       = 1'b0;
      doneWithStart[i] = 1'b0;
    end
    frameMode[0] = 2'd0;
    frameSeed[0] = 16'hD9E7;
    frameMode[1] = 2'd1;
`ifdef OLED_STREAMER_TESTPATTERN_EN
    frameTm[4]   = 1'b1;
`endif

    repeat (4) @(negedge clk);
    checkOutput("rstCsN",  bus.oled_cs_n, 1);
    checkOutput("rstSclk", bus.oled_sclk, 1);
    checkOutput("rstSdin", bus.oled_sdin, 0);
    checkOutput("rstDc",   bus.oled_dc, 1);
    checkOutput("rstPulses", {bus.frame_start, bus.frame_done}, 0);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstCoord", {bus.coordinate_x, bus.coordinate_y}, 0);

    // Frames 0 (constant D9E7) and 1 ({x,y,0}) run back to back.
    bus.enable = 1'b1;
    @(posedge clk);
    #2 rstN = 1'b1;
    waitDone(2, 2 * N * PIX + 50);

    // Frame 2: enable dropped part way; the frame must still complete.
    k = $urandom_range(N - 2, 1);
    waitPixel(3, k, N * PIX);
    bus.enable = 1'b0;
    waitDone(3, N * PIX + 50);
    repeat (2) @(negedge clk);
    checkOutput("idleCsN",  bus.oled_cs_n, 1);
    checkOutput("idleBusy", bus.busy, 0);
    checkOutput("idleSclk", bus.oled_sclk, 1);
    applyStimulus(1'b0, 3 * PIX);
    checkOutput("noRestart", frameNum, 3);
    checkOutput("backToBack0", doneWithStart[0], 1);
    checkOutput("backToBack1", doneWithStart[1], 1);
    checkOutput("stopAfter2",  doneWithStart[2], 0);

    // Frame 3: reset lands in the middle of a shifted word.
    bus.enable = 1'b1;
    k = $urandom_range(N - 2, 1);
    waitPixel(4, k, 2 * N * PIX);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midRstSclk",  bus.oled_sclk, 1);
    checkOutput("midRstCsN",   bus.oled_cs_n, 1);
    checkOutput("midRstBusy",  bus.busy, 0);
    checkOutput("midRstCoord", {bus.coordinate_x, bus.coordinate_y}, 0);
    repeat (3) @(negedge clk);
`ifdef OLED_STREAMER_TESTPATTERN_EN
    bus.test_mode = 1'b1;
`endif
    @(posedge clk);
    #2 rstN = 1'b1;

    // Frame 4 restarts at (0,0); test_mode changes after the start must
    // not affect it.
    waitPixel(5, 4, 2 * N * PIX);
`ifdef OLED_STREAMER_TESTPATTERN_EN
    bus.test_mode = 1'b0;
`endif
    bus.enable = 1'b0;
    waitDone(4, N * PIX + 50);
    applyStimulus(1'b0, 2 * PIX);
    checkOutput("noRestart2", frameNum, 5);
    checkOutput("stopAfter4", doneWithStart[3], 0);
    checkOutput("finalCsN", bus.oled_cs_n, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
